// File: rtl/reg_file_mp.sv
// Multi-ported register file with one-cycle registered reads, optional write-first
// forwarding, and a power-on clear sequence that walks every entry before RUN.
module reg_file_mp #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_READ   = 2,
  parameter int unsigned NUM_WRITE  = 2,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]  rd_addr_i,
  output logic [NUM_READ*DATA_WIDTH-1:0]  rd_data_o,
  input  logic [NUM_WRITE-1:0]            wr_en_i,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0] wr_data_i,
  output logic                            ready_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  state_e                       state_q;
  state_e                       state_d;
  logic                         ready_d_c;
  logic [ADDR_WIDTH-1:0]        clr_idx;
  logic [DATA_WIDTH-1:0]        mem [DEPTH];
  logic [NUM_WRITE-1:0]         we_c;
  logic [NUM_READ*DATA_WIDTH-1:0] rd_next_c;

  // State register; ready_o is registered alongside the state it reports
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      ready_o <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_o <= ready_d_c;
    end
  end

  // Next state: CLEAR ends on the edge that zeroes the last entry
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (clr_idx == {ADDR_WIDTH{1'b1}}) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  // Output decode
  always_comb begin
    ready_d_c = 1'b0;
    if (state_d == RUN) ready_d_c = 1'b1;
  end

  // Effective write enables: RUN only, address 0 is hardwired zero
  always_comb begin
    we_c = '0;
    for (int w = 0; w < NUM_WRITE; w++) begin
      we_c[w] = (state_q == RUN) && wr_en_i[w] &&
                (wr_addr_i[w*ADDR_WIDTH +: ADDR_WIDTH] != '0);
    end
  end

  // Read mux with optional forwarding; higher write port index wins collisions
  always_comb begin
    rd_next_c = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      rd_next_c[p*DATA_WIDTH +: DATA_WIDTH] = mem[rd_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH]];
      if (BYPASS != 0) begin
        for (int w = 0; w < NUM_WRITE; w++) begin
          if (we_c[w] && (wr_addr_i[w*ADDR_WIDTH +: ADDR_WIDTH] ==
                          rd_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH])) begin
            rd_next_c[p*DATA_WIDTH +: DATA_WIDTH] = wr_data_i[w*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
      if (rd_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH] == '0) begin
        rd_next_c[p*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
  end

  // Storage, clear walker and registered read data
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_idx   <= '0;
      mem[0]    <= '0;
      rd_data_o <= '0;
    end else if (state_q == CLEAR) begin
      mem[clr_idx] <= '0;
      clr_idx      <= clr_idx + ADDR_WIDTH'(1);
      rd_data_o    <= '0;
    end else begin
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (we_c[w]) begin
          mem[wr_addr_i[w*ADDR_WIDTH +: ADDR_WIDTH]] <= wr_data_i[w*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      rd_data_o <= rd_next_c;
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: a write-first and a read-first instance share stimulus and
// are checked against an array model of the register file.
module tb_reg_file_mp;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int NR    = 2;
  localparam int NW    = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [NR*AW-1:0] rd_addr;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic [NR*DW-1:0] rd_data_wf, rd_data_rf;
  logic             ready_wf, ready_rf;

  reg_file_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR), .NUM_WRITE(NW), .BYPASS(1)) dut_wf (
    .clk(clk), .reset(reset), .rd_addr_i(rd_addr), .rd_data_o(rd_data_wf),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .ready_o(ready_wf));

  reg_file_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR), .NUM_WRITE(NW), .BYPASS(0)) dut_rf (
    .clk(clk), .reset(reset), .rd_addr_i(rd_addr), .rd_data_o(rd_data_rf),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .ready_o(ready_rf));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model
  logic [DW-1:0]    m_mem [DEPTH];
  bit               m_ready;
  int               m_since;
  logic [NR*DW-1:0] exp_wf, exp_rf;

  task automatic cycle();
    logic [DW-1:0] after [DEPTH];
    logic [AW-1:0] a;
    @(posedge clk);
    if (reset) begin
      m_ready = 0; m_since = 0; exp_wf = '0; exp_rf = '0;
    end else if (!m_ready) begin
      exp_wf = '0; exp_rf = '0;
      m_since++;
      if (m_since == DEPTH) begin
        foreach (m_mem[i]) m_mem[i] = '0;
        m_ready = 1;
      end
    end else begin
      after = m_mem;
      for (int w = 0; w < NW; w++)
        if (wr_en[w] && wr_addr[w*AW +: AW] != '0) after[wr_addr[w*AW +: AW]] = wr_data[w*DW +: DW];
      for (int p = 0; p < NR; p++) begin
        a = rd_addr[p*AW +: AW];
        exp_wf[p*DW +: DW] = (a == '0) ? '0 : after[a];
        exp_rf[p*DW +: DW] = (a == '0) ? '0 : m_mem[a];
      end
      m_mem = after;
    end
    #1;
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle();
    cycle(); cycle();
    n_checks++;
    if (ready_wf !== 1'b0 || ready_rf !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: wf=%b rf=%b expected 0", ready_wf, ready_rf);
    end
    n_checks++;
    if (rd_data_wf !== '0 || rd_data_rf !== '0) begin
      n_fail++; $display("FAIL reset_rdata: wf=%h rf=%h expected 0", rd_data_wf, rd_data_rf);
    end
    reset = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      cycle();
      n_checks++;
      if (ready_wf !== (i == DEPTH) || ready_rf !== (i == DEPTH) || ready_wf !== m_ready) begin
        n_fail++;
        $display("FAIL clear_len cycle %0d: wf=%b rf=%b expected %b", i, ready_wf, ready_rf, i == DEPTH);
      end
    end
  endtask

  task automatic test_read_all_zero();
    for (int a = 0; a < DEPTH; a += 2) begin
      rd_addr[0 +: AW] = AW'(a);
      rd_addr[AW +: AW] = AW'(a + 1);
      cycle();
      n_checks++;
      if (rd_data_wf !== '0 || rd_data_rf !== '0) begin
        n_fail++; $display("FAIL read_zero addr %0d: wf=%h rf=%h expected 0", a, rd_data_wf, rd_data_rf);
      end
    end
  endtask

  task automatic test_write_read();
    idle();
    wr_en = 2'b01; wr_addr[0 +: AW] = 5'd5; wr_data[0 +: DW] = 32'hDEADBEEF;
    cycle();
    idle();
    rd_addr[AW +: AW] = 5'd5;
    cycle();
    n_checks++;
    if (rd_data_wf[DW +: DW] !== 32'hDEADBEEF || rd_data_rf[DW +: DW] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL write_read: wf=%h rf=%h expected deadbeef", rd_data_wf[DW +: DW], rd_data_rf[DW +: DW]);
    end
  endtask

  task automatic test_bypass();
    idle();
    wr_en = 2'b01; wr_addr[0 +: AW] = 5'd7; wr_data[0 +: DW] = 32'h12345678;
    rd_addr[0 +: AW] = 5'd7;
    cycle();
    n_checks++;
    if (rd_data_wf[0 +: DW] !== 32'h12345678) begin
      n_fail++; $display("FAIL bypass_wf: got %h expected 12345678", rd_data_wf[0 +: DW]);
    end
    n_checks++;
    if (rd_data_rf[0 +: DW] !== 32'h0) begin
      n_fail++; $display("FAIL bypass_rf: got %h expected 00000000", rd_data_rf[0 +: DW]);
    end
    wr_en = '0;
    cycle();
    n_checks++;
    if (rd_data_wf[0 +: DW] !== 32'h12345678 || rd_data_rf[0 +: DW] !== 32'h12345678) begin
      n_fail++; $display("FAIL bypass_after: wf=%h rf=%h expected 12345678", rd_data_wf[0 +: DW], rd_data_rf[0 +: DW]);
    end
  endtask

  task automatic test_port_priority();
    idle();
    wr_en = 2'b11;
    wr_addr[0 +: AW] = 5'd9; wr_data[0 +: DW] = 32'hAAAA0000;
    wr_addr[AW +: AW] = 5'd9; wr_data[DW +: DW] = 32'h5555FFFF;
    cycle();
    idle();
    rd_addr[0 +: AW] = 5'd9; rd_addr[AW +: AW] = 5'd9;
    cycle();
    n_checks++;
    if (rd_data_wf !== {2{32'h5555FFFF}} || rd_data_rf !== {2{32'h5555FFFF}}) begin
      n_fail++; $display("FAIL port1_wins: wf=%h rf=%h expected 5555ffff on both ports", rd_data_wf, rd_data_rf);
    end
    idle();
    wr_en = 2'b01; wr_addr[0 +: AW] = 5'd0; wr_data[0 +: DW] = 32'hFFFFFFFF;
    cycle();
    wr_en = '0;
    cycle();
    n_checks++;
    if (rd_data_wf !== '0 || rd_data_rf !== '0) begin
      n_fail++; $display("FAIL addr0_write: wf=%h rf=%h expected 0", rd_data_wf, rd_data_rf);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < NR; p++) rd_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
      for (int w = 0; w < NW; w++) begin
        wr_addr[w*AW +: AW] = AW'($urandom_range(0, 7));
        wr_data[w*DW +: DW] = $urandom;
      end
      wr_en = NW'($urandom_range(0, 3));
      cycle();
      n_checks++;
      if (rd_data_wf !== exp_wf || rd_data_rf !== exp_rf || ready_wf !== 1'b1) begin
        n_fail++;
        $display("FAIL random it %0d: wf=%h exp %h rf=%h exp %h ready=%b", i, rd_data_wf, exp_wf, rd_data_rf, exp_rf, ready_wf);
      end
      for (int p = 0; p < NR; p++) rd_addr[p*AW +: AW] = AW'($urandom_range(0, DEPTH - 1));
      #2;
      n_checks++;
      if (rd_data_wf !== exp_wf || rd_data_rf !== exp_rf) begin
        n_fail++;
        $display("FAIL hold it %0d: wf=%h exp %h rf=%h exp %h", i, rd_data_wf, exp_wf, rd_data_rf, exp_rf);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    idle();
    wr_en = 2'b01; wr_addr[0 +: AW] = 5'd3; wr_data[0 +: DW] = 32'h1;
    cycle();
    idle();
    reset = 1'b1; cycle(); reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_en = 2'b11;
      wr_addr = NW*AW'($urandom); wr_data = {$urandom, $urandom};
      rd_addr[0 +: AW] = 5'd3;
      cycle();
      n_checks++;
      if (rd_data_wf !== '0 || rd_data_rf !== '0 || ready_wf !== 1'b0) begin
        n_fail++; $display("FAIL first_clear %0d: wf=%h rf=%h ready=%b", i, rd_data_wf, rd_data_rf, ready_wf);
      end
    end
    reset = 1'b1; cycle(); reset = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      wr_en = 2'b11;
      wr_addr[0 +: AW] = 5'd3; wr_addr[AW +: AW] = AW'($urandom);
      wr_data = {$urandom, $urandom};
      cycle();
      n_checks++;
      if (ready_wf !== (i == DEPTH) || ready_rf !== (i == DEPTH) || rd_data_wf !== '0) begin
        n_fail++;
        $display("FAIL reclear cycle %0d: ready wf=%b rf=%b expected %b rd=%h", i, ready_wf, ready_rf, i == DEPTH, rd_data_wf);
      end
    end
    idle();
    rd_addr[0 +: AW] = 5'd3;
    cycle();
    n_checks++;
    if (rd_data_wf[0 +: DW] !== 32'h0 || rd_data_rf[0 +: DW] !== 32'h0) begin
      n_fail++; $display("FAIL addr3_cleared: wf=%h rf=%h expected 0", rd_data_wf[0 +: DW], rd_data_rf[0 +: DW]);
    end
    for (int a = 0; a < DEPTH; a += 2) begin
      rd_addr[0 +: AW] = AW'(a);
      rd_addr[AW +: AW] = AW'(a + 1);
      cycle();
      n_checks++;
      if (rd_data_wf !== '0 || rd_data_rf !== '0 || rd_data_wf !== exp_wf) begin
        n_fail++; $display("FAIL clear_contents addr %0d: wf=%h rf=%h expected 0", a, rd_data_wf, rd_data_rf);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_read_all_zero();
    test_write_read();
    test_bypass();
    test_port_priority();
    test_random();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
